ets_phase_sweep: RTL and testbench

Sweep controller for the equivalent-time-sampling path.
- Drives the MMCM dynamic phase-shift port (ps_en/ps_incdec/ps_done) one fine step at a time.
- At each phase position it waits for the sampler to settle, then counts comparator hits on cmp_data over a fixed window.
- Emits one (step, count) record per position on a valid/ready stream to the capture/DMA side.
- Sits between the host control registers and the ETS serve top: it feeds that block's phase-shift inputs and consumes its cmp_data and locked outputs.

---
 rtl/ets_phase_sweep_if.sv | 19 +
 rtl/ets_phase_sweep.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ets_phase_sweep.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ets_phase_sweep_if.sv
// Record stream between the phase-sweep controller and the capture/DMA side.
//   m_valid  record valid (master -> slave)
//   m_ready  downstream accept (slave -> master)
//   m_step   phase index of the record
//   m_count  comparator hit count for that position
//   m_last   record belongs to the final phase position
interface ets_phase_sweep_if #(
  parameter int STEP_W = 9,
  parameter int CNT_W  = 9
);
  logic              m_valid;
  logic              m_ready;
  logic [STEP_W-1:0] m_step;
  logic [CNT_W-1:0]  m_count;
  logic              m_last;

  modport master (output m_valid, m_step, m_count, m_last, input m_ready);
  modport slave  (input m_valid, m_step, m_count, m_last, output m_ready);
endinterface

// File: rtl/ets_phase_sweep.sv
// Equivalent-time-sampling phase sweep controller.
// Steps the MMCM dynamic phase-shift port one fine step at a time; at each
// position it waits SETTLE_CYC cycles, counts cmp_data hits over ACC_LEN
// cycles and emits one (step, count) record on the rec stream.
//
// Ports:
//   ps_clk        sole clock (same clock as the MMCM phase-shift port)
//   free_run_rst  synchronous active-high reset
//   start/abort   one-cycle sweep start / stop requests
//   dir           shift direction sampled at start (1 = increment)
//   locked        MMCM lock
//   cmp_data      comparator sample, synchronous to ps_clk
//   ps_en/ps_incdec/ps_done  MMCM dynamic phase-shift handshake
//   rec           record stream (m_valid/m_ready/m_step/m_count/m_last)
//   busy          high outside IDLE
//   done          one-cycle pulse on normal sweep completion
//   err           sticky fault (timeout or lock loss), cleared by start
//
// Optional feature: define ETS_SWEEP_RETURN_EN to shift the MMCM back to its
// starting phase after the last record (RETURN state).
module ets_phase_sweep #(
  parameter int STEPS      = 448,
  parameter int SETTLE_CYC = 16,
  parameter int ACC_LEN    = 256,
  parameter int TIMEOUT    = 64,
  parameter int STEP_W     = 9,
  parameter int CNT_W      = 9
) (
  input  logic                     ps_clk,
  input  logic                     free_run_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     dir,
  input  logic                     locked,
  input  logic                     cmp_data,
  output logic                     ps_en,
  output logic                     ps_incdec,
  input  logic                     ps_done,
  ets_phase_sweep_if.master        rec,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CYC_MAX = (SETTLE_CYC > ACC_LEN)
                         ? ((SETTLE_CYC > TIMEOUT) ? SETTLE_CYC : TIMEOUT)
                         : ((ACC_LEN > TIMEOUT) ? ACC_LEN : TIMEOUT);
  localparam int CYC_W = $clog2(CYC_MAX + 1);

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(STEPS - 1);
  localparam logic [CYC_W-1:0]  SETTLE_END = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0]  ACC_END    = CYC_W'(ACC_LEN - 1);
  localparam logic [CYC_W-1:0]  TO_END     = CYC_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_LOCK,
    S_SETTLE,
    S_ACC,
    S_OUT,
    S_SHIFT,
    S_WAIT_DONE,
`ifdef ETS_SWEEP_RETURN_EN
    S_RETURN,
`endif
    S_FIN,
    S_ERR
  } state_t;

  state_t              state, state_nxt;
  logic [STEP_W-1:0]   step;
  logic [CYC_W-1:0]    cyc;
  logic [CNT_W-1:0]    acc;
  logic                dir_q;
  logic                err_q;
  logic                abort_pend;

  logic                start_ok;
  logic                abort_now;
  logic                waiting;
  logic                set_err;
  logic                step_inc;

`ifdef ETS_SWEEP_RETURN_EN
  logic                ret_wait;
  logic [STEP_W-1:0]   rcnt;
  logic                ret_issue;
  logic                ret_step;
`endif

  assign start_ok  = (state == S_IDLE) && start && !abort;
  // An abort raised while a shift is outstanding is only acted on once the
  // MMCM reports completion (or times out).
  assign abort_now = abort || abort_pend;

`ifdef ETS_SWEEP_RETURN_EN
  assign waiting = (state == S_WAIT_DONE) || ((state == S_RETURN) && ret_wait);
`else
  assign waiting = (state == S_WAIT_DONE);
`endif

  always_ff @(posedge ps_clk) begin
    if (free_run_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ps_en     = 1'b0;
    set_err   = 1'b0;
    step_inc  = 1'b0;
`ifdef ETS_SWEEP_RETURN_EN
    ret_issue = 1'b0;
    ret_step  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start_ok) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (abort)       state_nxt = S_IDLE;
        else if (locked) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (abort) state_nxt = S_IDLE;
        else if (!locked) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else if (cyc == SETTLE_END) state_nxt = S_ACC;
      end
      S_ACC: begin
        if (abort) state_nxt = S_IDLE;
        else if (!locked) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else if (cyc == ACC_END) state_nxt = S_OUT;
      end
      S_OUT: begin
        if (abort) state_nxt = S_IDLE;
        else if (!locked) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else if (rec.m_ready) begin
          if (step == LAST_STEP) begin
`ifdef ETS_SWEEP_RETURN_EN
            state_nxt = (STEPS > 1) ? S_RETURN : S_FIN;
`else
            state_nxt = S_FIN;
`endif
          end else begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // ps_en is withheld when leaving on abort or lock loss so the MMCM is
        // never handed a shift the FSM will not wait for.
        if (abort) state_nxt = S_IDLE;
        else if (!locked) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          ps_en     = 1'b1;
          state_nxt = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!locked) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end else if (ps_done) begin
          if (abort_now) state_nxt = S_IDLE;
          else begin
            step_inc  = 1'b1;
            state_nxt = S_SETTLE;
          end
        end else if (cyc == TO_END) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end
      end
`ifdef ETS_SWEEP_RETURN_EN
      S_RETURN: begin
        // Alternates between issuing a reverse shift and waiting for it.
        if (!ret_wait) begin
          if (abort) state_nxt = S_IDLE;
          else begin
            ps_en     = 1'b1;
            ret_issue = 1'b1;
          end
        end else if (ps_done) begin
          if (abort_now)                         state_nxt = S_IDLE;
          else if (rcnt == LAST_STEP - 1'b1)     state_nxt = S_FIN;
          else                                   ret_step  = 1'b1;
        end else if (cyc == TO_END) begin
          set_err   = 1'b1;
          state_nxt = S_ERR;
        end
      end
`endif
      S_FIN:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ps_clk) begin
    if (free_run_rst) begin
      step       <= '0;
      cyc        <= '0;
      acc        <= '0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      // Shared cycle counter for settle, accumulate and timeout windows;
      // restarts on every state change and on every issued shift.
      if ((state_nxt != state) || ps_en) cyc <= '0;
      else                               cyc <= cyc + 1'b1;

      if ((state == S_SETTLE) && (state_nxt == S_ACC)) acc <= '0;
      else if (state == S_ACC)                          acc <= acc + CNT_W'(cmp_data);

      if (start_ok)      step <= '0;
      else if (step_inc) step <= step + 1'b1;

      if (start_ok) dir_q <= dir;

      if (start_ok)     err_q <= 1'b0;
      else if (set_err) err_q <= 1'b1;

      if (state_nxt == S_IDLE)    abort_pend <= 1'b0;
      else if (waiting && abort)  abort_pend <= 1'b1;
    end
  end

`ifdef ETS_SWEEP_RETURN_EN
  always_ff @(posedge ps_clk) begin
    if (free_run_rst) begin
      ret_wait <= 1'b0;
      rcnt     <= '0;
    end else if (state != S_RETURN) begin
      ret_wait <= 1'b0;
      rcnt     <= '0;
    end else begin
      if (ret_issue)     ret_wait <= 1'b1;
      else if (ret_step) ret_wait <= 1'b0;
      if (ret_step) rcnt <= rcnt + 1'b1;
    end
  end

  assign ps_incdec = dir_q ^ (state == S_RETURN);
`else
  assign ps_incdec = dir_q;
`endif

  assign rec.m_valid = (state == S_OUT);
  assign rec.m_step  = step;
  assign rec.m_count = acc;
  assign rec.m_last  = (state == S_OUT) && (step == LAST_STEP);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_FIN);
  // err rises in the same cycle the fault is detected, ahead of ERR.
  assign err         = err_q || set_err;

endmodule

// File: tb/tb_ets_phase_sweep.sv
// Self-checking bench for ets_phase_sweep: STEPS=4, SETTLE_CYC=2, ACC_LEN=8,
// TIMEOUT=16; the MMCM model answers ps_en with ps_done 5 cycles later.
// Expected records are queued by the stimulus and checked by a monitor.
module tb_ets_phase_sweep;
  localparam int STEPS      = 4;
  localparam int SETTLE_CYC = 2;
  localparam int ACC_LEN    = 8;
  localparam int TIMEOUT    = 16;
  localparam int STEP_W     = 2;
  localparam int CNT_W      = 4;

  logic ps_clk = 1'b0;
  logic free_run_rst, start, abort, dir, locked, cmp_data;
  logic ps_en, ps_incdec, ps_done, busy, done, err;

  ets_phase_sweep_if #(.STEP_W(STEP_W), .CNT_W(CNT_W)) rec ();

  ets_phase_sweep #(
    .STEPS(STEPS), .SETTLE_CYC(SETTLE_CYC), .ACC_LEN(ACC_LEN),
    .TIMEOUT(TIMEOUT), .STEP_W(STEP_W), .CNT_W(CNT_W)
  ) dut (
    .ps_clk(ps_clk), .free_run_rst(free_run_rst), .start(start),
    .abort(abort), .dir(dir), .locked(locked), .cmp_data(cmp_data),
    .ps_en(ps_en), .ps_incdec(ps_incdec), .ps_done(ps_done), .rec(rec),
    .busy(busy), .done(done), .err(err)
  );

  always #5 ps_clk = ~ps_clk;

  int cyc = 0;
  always @(posedge ps_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    int step;
    int count;
    int last;
  } rec_t;
  rec_t exp_q[$];

  task automatic push_rec(input int s, input int c, input int l);
    rec_t r;
    r.step = s; r.count = c; r.last = l;
    exp_q.push_back(r);
  endtask

  // Monitor / scoreboard state
  int pe_cnt, pe_up, pe_dn, done_cnt, rec_cnt;
  int first_valid_cyc, pd_cyc, done_cyc, err_rise_cyc, busy_fall_cyc;
  int pe_cyc[$];
  logic err_d = 1'b0, busy_d = 1'b0;

  always @(negedge ps_clk) begin
    if (!free_run_rst) begin
      if (ps_en) begin
        pe_cnt++;
        pe_cyc.push_back(cyc);
        if (ps_incdec) pe_up++; else pe_dn++;
      end
      if (ps_done) pd_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err && !err_d) err_rise_cyc = cyc;
      if (!busy && busy_d) busy_fall_cyc = cyc;
      err_d = err;
      busy_d = busy;
      if (rec.m_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rec.m_ready) begin
          rec_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_record", 1, 0);
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            check("rec_step", int'(rec.m_step), e.step);
            check("rec_count", int'(rec.m_count), e.count);
            check("rec_last", int'(rec.m_last), e.last);
          end
        end
      end
    end
  end

  // MMCM phase-shift model: ps_done 5 cycles after ps_en, optionally only
  // for the first model_limit shifts of a sweep (0 = no limit).
  int model_limit = 0;
  int model_shifts = 0;
  initial begin
    ps_done = 1'b0;
    forever begin
      @(negedge ps_clk);
      if (ps_en && !free_run_rst) begin
        model_shifts++;
        if (model_limit == 0 || model_shifts <= model_limit) begin
          repeat (5) @(posedge ps_clk);
          #1 ps_done = 1'b1;
          @(posedge ps_clk);
          #1 ps_done = 1'b0;
        end
      end
    end
  end

  // Comparator source: constant 1 or alternating 1,0.
  bit cmp_mode = 1'b0;
  initial begin
    cmp_data = 1'b1;
    forever begin
      @(posedge ps_clk);
      #1 cmp_data = cmp_mode ? ~cmp_data : 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ps_clk);
    #1;
  endtask

  task automatic clear_stats();
    pe_cnt = 0; pe_up = 0; pe_dn = 0; done_cnt = 0; rec_cnt = 0;
    first_valid_cyc = -1; pd_cyc = -1; done_cyc = -1;
    err_rise_cyc = -1; busy_fall_cyc = -1;
    pe_cyc.delete();
    model_shifts = 0;
  endtask

  task automatic do_start(input logic d, output int t);
    t = cyc;
    start = 1'b1;
    dir = d;
    tick(1);
    start = 1'b0;
  endtask

  // which: 0 ps_en, 1 ps_done, 2 m_valid, 3 busy low
  task automatic wait_sig(input int which, input int budget, output int at);
    int n = 0;
    at = -1;
    while (at < 0 && n < budget) begin
      @(negedge ps_clk);
      n++;
      if ((which == 0 && ps_en) || (which == 1 && ps_done) ||
          (which == 2 && rec.m_valid) || (which == 3 && !busy))
        at = cyc;
    end
    if (at < 0) check($sformatf("wait_expired_%0d", which), 0, 1);
  endtask

  task automatic wait_idle();
    int at;
    wait_sig(3, 300, at);
    @(posedge ps_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, p, d, v;
    free_run_rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0;
    locked = 1'b0; rec.m_ready = 1'b0;
    clear_stats();
    tick(3);
    free_run_rst = 1'b0;

    // Reset values
    check("rst_ps_en", int'(ps_en), 0);
    check("rst_ps_incdec", int'(ps_incdec), 0);
    check("rst_m_valid", int'(rec.m_valid), 0);
    check("rst_m_step", int'(rec.m_step), 0);
    check("rst_m_count", int'(rec.m_count), 0);
    check("rst_m_last", int'(rec.m_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    // Full sweep, cmp=1, always ready
    clear_stats();
    locked = 1'b1; rec.m_ready = 1'b1; cmp_mode = 1'b0;
    for (int s = 0; s < STEPS; s++) push_rec(s, 8, (s == STEPS - 1) ? 1 : 0);
    do_start(1'b1, t);
    wait_idle();
    check("t1_first_valid", first_valid_cyc, t + 12);
    check("t1_first_ps_en", (pe_cyc.size() > 0) ? pe_cyc[0] : -1, t + 13);
    check("t1_records", rec_cnt, 4);
    check("t1_queue_left", exp_q.size(), 0);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_err", int'(err), 0);
    check("t1_incdec_idle", int'(ps_incdec), 1);
`ifdef ETS_SWEEP_RETURN_EN
    check("t1_ps_en_cnt", pe_cnt, 6);
    check("t1_ps_en_up", pe_up, 3);
    check("t1_ps_en_down", pe_dn, 3);
    check("t1_done_cyc", done_cyc, t + 82);
    check("t1_done_after_ps_done", done_cyc, pd_cyc + 1);
`else
    check("t1_ps_en_cnt", pe_cnt, 3);
    check("t1_ps_en_up", pe_up, 3);
    check("t1_done_cyc", done_cyc, t + 64);
`endif

    // Alternating cmp, 10-cycle stall on the first record
    clear_stats();
    cmp_mode = 1'b1; rec.m_ready = 1'b0;
    for (int s = 0; s < STEPS; s++) push_rec(s, 4, (s == STEPS - 1) ? 1 : 0);
    do_start(1'b1, t);
    wait_sig(2, 100, v);
    for (int i = 0; i < 10; i++) begin
      check("t2_stall_hold",
            int'({rec.m_valid, rec.m_step, rec.m_count, rec.m_last}),
            int'({1'b1, 2'd0, 4'd4, 1'b0}));
      if (i < 9) @(negedge ps_clk);
    end
    @(posedge ps_clk);
    #1 rec.m_ready = 1'b1;
    wait_idle();
    check("t2_records", rec_cnt, 4);
    check("t2_queue_left", exp_q.size(), 0);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_err", int'(err), 0);
    cmp_mode = 1'b0;

    // ps_done stops after the 2nd shift -> timeout
    clear_stats();
    model_limit = 2;
    for (int s = 0; s < 3; s++) push_rec(s, 8, 0);
    do_start(1'b0, t);
    wait_idle();
    check("t3_err", int'(err), 1);
    check("t3_ps_en_cnt", pe_cnt, 3);
    check("t3_ps_en_down", pe_dn, 3);
    check("t3_err_rise", err_rise_cyc, (pe_cyc.size() > 2) ? pe_cyc[2] + 16 : -1);
    check("t3_busy_fall", busy_fall_cyc, err_rise_cyc + 2);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_records", rec_cnt, 3);
    check("t3_queue_left", exp_q.size(), 0);
    model_limit = 0;

    // Abort while a shift is outstanding
    clear_stats();
    push_rec(0, 8, 0);
    do_start(1'b1, t);
    wait_sig(0, 100, p);
    tick(1);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_idle();
    check("t4_busy_fall", busy_fall_cyc, p + 6);
    check("t4_err", int'(err), 0);
    tick(20);
    check("t4_records", rec_cnt, 1);
    check("t4_ps_en_cnt", pe_cnt, 1);
    check("t4_done_cnt", done_cnt, 0);
    check("t4_m_valid", int'(rec.m_valid), 0);
    check("t4_queue_left", exp_q.size(), 0);

    // Lock loss during ACC of step 1, then restart clears err
    clear_stats();
    push_rec(0, 8, 0);
    do_start(1'b1, t);
    wait_sig(1, 100, d);
    tick(5);
    locked = 1'b0;
    wait_idle();
    check("t5_err", int'(err), 1);
    check("t5_err_rise", err_rise_cyc, d + 5);
    check("t5_busy_fall", busy_fall_cyc, d + 7);
    check("t5_records", rec_cnt, 1);
    check("t5_done_cnt", done_cnt, 0);
    check("t5_queue_left", exp_q.size(), 0);
    locked = 1'b1;
    tick(2);
    check("t5_err_held", int'(err), 1);
    do_start(1'b1, t);
    check("t5_err_cleared", int'(err), 0);
    check("t5_busy_restart", int'(busy), 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_abort_idle", int'(busy), 0);
    tick(5);
    check("t5_no_done", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
